// File: rtl/dsp_seq_pkg.sv
// rtl/dsp_seq_pkg.sv - shared state encoding, default parameters and constants for the config sequencer
package dsp_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MUTE   = 3'd1,
    ST_APPLY  = 3'd2,
    ST_FLUSH  = 3'd3,
    ST_UNMUTE = 3'd4
  } state_t;

  localparam int CNT_W = 16;

  localparam int DEF_MUTE_CYCLES    = 512;
  localparam int DEF_FLUSH_SAMPLES  = 16;
  localparam int DEF_UNMUTE_CYCLES  = 512;
  localparam int DEF_TIMEOUT_CYCLES = 4096;

  localparam logic [15:0] VOL_RESET = 16'h7FFF;

  // Terminal count for an N-cycle dwell; counters start at zero on state entry.
  function automatic logic [CNT_W-1:0] cnt_last(input int n);
    if (n > 0) return CNT_W'(n - 1);
    else return '0;
  endfunction

endpackage

// File: rtl/dsp_seq_counter.sv
// rtl/dsp_seq_counter.sv - 16-bit saturating counter with synchronous clear and count enable
module dsp_seq_counter
  import dsp_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  // Clear wins over enable; the count sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/dsp_config_sequencer.sv
// rtl/dsp_config_sequencer.sv - glitch-free DSP reconfiguration sequencer; DSP_SEQ_FLUSH_TIMEOUT_EN enables the flush watchdog
module dsp_config_sequencer
  import dsp_seq_pkg::*;
#(
  parameter int MUTE_CYCLES    = DEF_MUTE_CYCLES,
  parameter int FLUSH_SAMPLES  = DEF_FLUSH_SAMPLES,
  parameter int UNMUTE_CYCLES  = DEF_UNMUTE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [3:0]  cfg_osr_sel,
  input  logic        cfg_deemp,
  input  logic [15:0] cfg_volume_q15,
  input  logic        host_mute,
  input  logic        dsp_out_valid,
  output logic [3:0]  osr_sel,
  output logic        deemp_enable,
  output logic [15:0] volume_q15,
  output logic        soft_mute,
  output logic        cfg_done,
  output logic        busy,
  output logic        flush_timeout
);

  localparam logic [CNT_W-1:0] MUTE_LAST   = cnt_last(MUTE_CYCLES);
  localparam logic [CNT_W-1:0] FLUSH_LAST  = cnt_last(FLUSH_SAMPLES);
  localparam logic [CNT_W-1:0] UNMUTE_LAST = cnt_last(UNMUTE_CYCLES);
  localparam logic [CNT_W-1:0] TO_LAST     = cnt_last(TIMEOUT_CYCLES);

`ifdef DSP_SEQ_FLUSH_TIMEOUT_EN
  localparam bit WDOG_EN = 1'b1;
`else
  localparam bit WDOG_EN = 1'b0;
`endif

  state_t r_state;
  state_t w_state_next;

  logic [3:0]       r_cap_osr;
  logic             r_cap_deemp;
  logic [15:0]      r_cap_vol;
  logic [3:0]       r_osr_sel;
  logic             r_deemp;
  logic [15:0]      r_volume;
  logic             r_soft_mute;
  logic             r_cfg_done;
  logic             r_fast_pend;

  logic             w_cfg_ready;
  logic             w_xfer;
  logic             w_fast;
  logic             w_state_chg;
  logic             w_cyc_clr;
  logic             w_smp_en;
  logic             w_timeout;
  logic             w_done_set;
  logic             w_mute_force;
  logic [CNT_W-1:0] w_cyc_cnt;
  logic [CNT_W-1:0] w_smp_cnt;

  assign w_cfg_ready = (r_state == ST_IDLE);
  assign w_xfer      = cfg_valid && w_cfg_ready;
  // Only an OSR or de-emphasis change disturbs the filter state and needs a mute.
  assign w_fast      = (cfg_osr_sel == r_osr_sel) && (cfg_deemp == r_deemp);
  assign w_state_chg = (w_state_next != r_state);
  // In FLUSH the cycle counter measures silence since the last sample, for the watchdog.
  assign w_cyc_clr   = w_state_chg || ((r_state == ST_FLUSH) && dsp_out_valid);
  assign w_smp_en    = (r_state == ST_FLUSH) && dsp_out_valid;
  assign w_timeout   = WDOG_EN && (r_state == ST_FLUSH) && !dsp_out_valid &&
                       (w_cyc_cnt == TO_LAST);

  dsp_seq_counter u_cyc_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_cyc_clr),
    .en    (1'b1),
    .count (w_cyc_cnt)
  );

  dsp_seq_counter u_smp_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_state_chg),
    .en    (w_smp_en),
    .count (w_smp_cnt)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode, completion strobe and forced-mute request.
  always_comb begin
    w_state_next = r_state;
    w_done_set   = 1'b0;
    w_mute_force = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_xfer && !w_fast) w_state_next = ST_MUTE;
      end
      ST_MUTE: begin
        if (w_cyc_cnt == MUTE_LAST) w_state_next = ST_APPLY;
      end
      ST_APPLY: begin
        w_state_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (dsp_out_valid && (w_smp_cnt == FLUSH_LAST)) w_state_next = ST_UNMUTE;
        else if (w_timeout) w_state_next = ST_UNMUTE;
      end
      ST_UNMUTE: begin
        if (w_cyc_cnt == UNMUTE_LAST) begin
          w_state_next = ST_IDLE;
          w_done_set   = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
    w_mute_force = (w_state_next == ST_MUTE) || (w_state_next == ST_APPLY) ||
                   (w_state_next == ST_FLUSH);
  end

  // Capture the request on the handshake edge and drive the live DSP settings.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cap_osr   <= '0;
      r_cap_deemp <= 1'b0;
      r_cap_vol   <= VOL_RESET;
      r_osr_sel   <= '0;
      r_deemp     <= 1'b0;
      r_volume    <= VOL_RESET;
    end else begin
      if (w_xfer) begin
        r_cap_osr   <= cfg_osr_sel;
        r_cap_deemp <= cfg_deemp;
        r_cap_vol   <= cfg_volume_q15;
        if (w_fast) r_volume <= cfg_volume_q15;
      end
      if (r_state == ST_APPLY) begin
        r_osr_sel <= r_cap_osr;
        r_deemp   <= r_cap_deemp;
        r_volume  <= r_cap_vol;
      end
    end
  end

  // Soft mute follows the host one cycle late except while the datapath is unsettled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_soft_mute <= 1'b0;
    end else begin
      r_soft_mute <= w_mute_force ? 1'b1 : host_mute;
    end
  end

  // cfg_done pulses the cycle after a fast-path update or on return to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fast_pend <= 1'b0;
      r_cfg_done  <= 1'b0;
    end else begin
      r_fast_pend <= w_xfer && w_fast;
      r_cfg_done  <= w_done_set || r_fast_pend;
    end
  end

`ifdef DSP_SEQ_FLUSH_TIMEOUT_EN
  logic r_flush_timeout;

  // Sticky watchdog flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flush_timeout <= 1'b0;
    end else if (w_timeout) begin
      r_flush_timeout <= 1'b1;
    end
  end

  assign flush_timeout = r_flush_timeout;
`else
  assign flush_timeout = 1'b0;
`endif

  assign cfg_ready    = w_cfg_ready;
  assign busy         = (r_state != ST_IDLE);
  assign osr_sel      = r_osr_sel;
  assign deemp_enable = r_deemp;
  assign volume_q15   = r_volume;
  assign soft_mute    = r_soft_mute;
  assign cfg_done     = r_cfg_done;

endmodule

// File: tb/tb_dsp_config_sequencer.sv
// tb/tb_dsp_config_sequencer.sv - directed self-checking bench for dsp_config_sequencer
`timescale 1ns/1ps
module tb_dsp_config_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [3:0]  cfg_osr_sel;
  logic        cfg_deemp;
  logic [15:0] cfg_volume_q15;
  logic        host_mute;
  logic        dsp_out_valid;
  logic [3:0]  osr_sel;
  logic        deemp_enable;
  logic [15:0] volume_q15;
  logic        soft_mute;
  logic        cfg_done;
  logic        busy;
  logic        flush_timeout;

  int checks = 0;
  int errors = 0;

  dsp_config_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_osr_sel    (cfg_osr_sel),
    .cfg_deemp      (cfg_deemp),
    .cfg_volume_q15 (cfg_volume_q15),
    .host_mute      (host_mute),
    .dsp_out_valid  (dsp_out_valid),
    .osr_sel        (osr_sel),
    .deemp_enable   (deemp_enable),
    .volume_q15     (volume_q15),
    .soft_mute      (soft_mute),
    .cfg_done       (cfg_done),
    .busy           (busy),
    .flush_timeout  (flush_timeout)
  );

  always #5 clk = ~clk;

  // Present a request for one cycle; returns at the falling edge after the handshake.
  task automatic send_cfg(input logic [3:0] osr, input logic de, input logic [15:0] vol);
    cfg_osr_sel    = osr;
    cfg_deemp      = de;
    cfg_volume_q15 = vol;
    cfg_valid      = 1'b1;
    @(negedge clk);
    cfg_valid      = 1'b0;
  endtask

  // n strobes, one idle cycle before each; returns at the falling edge after the last strobe.
  task automatic send_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      dsp_out_valid = 1'b0;
      @(negedge clk);
      dsp_out_valid = 1'b1;
      @(negedge clk);
    end
    dsp_out_valid = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if (osr_sel !== 4'h0) begin errors++; $display("FAIL rst_osr: got %0h exp 0", osr_sel); end
    checks++; if (deemp_enable !== 1'b0) begin errors++; $display("FAIL rst_deemp: got %0b exp 0", deemp_enable); end
    checks++; if (volume_q15 !== 16'h7FFF) begin errors++; $display("FAIL rst_vol: got %h exp 7fff", volume_q15); end
    checks++; if ({soft_mute, cfg_done, busy, flush_timeout} !== 4'b0000) begin errors++; $display("FAIL rst_flags: got %b exp 0000", {soft_mute, cfg_done, busy, flush_timeout}); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %0b exp 1", cfg_ready); end
  endtask

  task automatic test_slow_path;
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL slow_ready: got %0b exp 1", cfg_ready); end
    send_cfg(4'd1, 1'b0, 16'h4000);
    checks++; if ({soft_mute, busy, cfg_ready} !== 3'b110) begin errors++; $display("FAIL slow_mute_rise: got %b exp 110", {soft_mute, busy, cfg_ready}); end
    repeat (512) @(negedge clk);
    checks++; if (osr_sel !== 4'd0) begin errors++; $display("FAIL slow_osr_early: got %0h exp 0", osr_sel); end
    @(negedge clk);
    checks++; if ({osr_sel, deemp_enable, volume_q15} !== {4'd1, 1'b0, 16'h4000}) begin errors++; $display("FAIL slow_apply: got %h/%b/%h exp 1/0/4000", osr_sel, deemp_enable, volume_q15); end
    send_pulses(15);
    checks++; if ({soft_mute, busy} !== 2'b11) begin errors++; $display("FAIL slow_flush_hold: got %b exp 11", {soft_mute, busy}); end
    send_pulses(1);
    checks++; if ({soft_mute, busy, cfg_done} !== 3'b010) begin errors++; $display("FAIL slow_unmute: got %b exp 010", {soft_mute, busy, cfg_done}); end
    repeat (511) @(negedge clk);
    checks++; if ({cfg_done, busy} !== 2'b01) begin errors++; $display("FAIL slow_done_early: got %b exp 01", {cfg_done, busy}); end
    @(negedge clk);
    checks++; if ({cfg_done, busy, cfg_ready} !== 3'b101) begin errors++; $display("FAIL slow_done: got %b exp 101", {cfg_done, busy, cfg_ready}); end
    @(negedge clk);
    checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL slow_done_width: got %0b exp 0", cfg_done); end
  endtask

  task automatic test_fast_path;
    send_cfg(4'd1, 1'b0, 16'h2000);
    checks++; if ({volume_q15, busy, soft_mute, cfg_done} !== {16'h2000, 3'b000}) begin errors++; $display("FAIL fast_vol: got %h/%b exp 2000/000", volume_q15, {busy, soft_mute, cfg_done}); end
    @(negedge clk);
    checks++; if ({cfg_done, soft_mute, busy} !== 3'b100) begin errors++; $display("FAIL fast_done: got %b exp 100", {cfg_done, soft_mute, busy}); end
    @(negedge clk);
    checks++; if ({cfg_done, soft_mute} !== 2'b00) begin errors++; $display("FAIL fast_done_width: got %b exp 00", {cfg_done, soft_mute}); end
  endtask

  task automatic test_busy_ignore;
    send_cfg(4'd2, 1'b1, 16'h1000);
    cfg_osr_sel    = 4'd3;
    cfg_deemp      = 1'b0;
    cfg_volume_q15 = 16'h0800;
    cfg_valid      = 1'b1;
    checks++; if ({cfg_ready, busy} !== 2'b01) begin errors++; $display("FAIL busy_ready: got %b exp 01", {cfg_ready, busy}); end
    repeat (513) @(negedge clk);
    checks++; if ({osr_sel, deemp_enable, volume_q15} !== {4'd2, 1'b1, 16'h1000}) begin errors++; $display("FAIL busy_apply: got %h/%b/%h exp 2/1/1000", osr_sel, deemp_enable, volume_q15); end
    send_pulses(16);
    repeat (511) @(negedge clk);
    checks++; if ({cfg_ready, osr_sel} !== {1'b0, 4'd2}) begin errors++; $display("FAIL busy_hold: got %b/%h exp 0/2", cfg_ready, osr_sel); end
    @(negedge clk);
    checks++; if ({cfg_done, cfg_ready, osr_sel} !== {2'b11, 4'd2}) begin errors++; $display("FAIL busy_done: got %b/%h exp 11/2", {cfg_done, cfg_ready}, osr_sel); end
    @(negedge clk);
    cfg_valid = 1'b0;
    checks++; if ({busy, cfg_ready, soft_mute} !== 3'b101) begin errors++; $display("FAIL busy_second_xfer: got %b exp 101", {busy, cfg_ready, soft_mute}); end
    repeat (513) @(negedge clk);
    checks++; if ({osr_sel, deemp_enable, volume_q15} !== {4'd3, 1'b0, 16'h0800}) begin errors++; $display("FAIL busy_second_apply: got %h/%b/%h exp 3/0/0800", osr_sel, deemp_enable, volume_q15); end
    send_pulses(16);
    repeat (512) @(negedge clk);
    checks++; if (cfg_done !== 1'b1) begin errors++; $display("FAIL busy_second_done: got %0b exp 1", cfg_done); end
    @(negedge clk);
  endtask

  task automatic test_host_mute;
    host_mute = 1'b1;
    #1;
    checks++; if (soft_mute !== 1'b0) begin errors++; $display("FAIL hm_latency: got %0b exp 0", soft_mute); end
    @(negedge clk);
    checks++; if (soft_mute !== 1'b1) begin errors++; $display("FAIL hm_idle_rise: got %0b exp 1", soft_mute); end
    send_cfg(4'd4, 1'b0, 16'h3000);
    repeat (513) @(negedge clk);
    send_pulses(16);
    checks++; if ({soft_mute, busy} !== 2'b11) begin errors++; $display("FAIL hm_unmute: got %b exp 11", {soft_mute, busy}); end
    repeat (512) @(negedge clk);
    checks++; if ({cfg_done, soft_mute} !== 2'b11) begin errors++; $display("FAIL hm_done: got %b exp 11", {cfg_done, soft_mute}); end
    @(negedge clk);
    checks++; if (soft_mute !== 1'b1) begin errors++; $display("FAIL hm_idle_hold: got %0b exp 1", soft_mute); end
    host_mute = 1'b0;
    @(negedge clk);
    checks++; if (soft_mute !== 1'b0) begin errors++; $display("FAIL hm_release: got %0b exp 0", soft_mute); end
  endtask

  task automatic test_reset_mid;
    logic seen_done;
    send_cfg(4'd7, 1'b1, 16'h1234);
    repeat (513) @(negedge clk);
    send_pulses(3);
    checks++; if ({busy, soft_mute, osr_sel} !== {2'b11, 4'd7}) begin errors++; $display("FAIL rm_pre: got %b/%h exp 11/7", {busy, soft_mute}, osr_sel); end
    rst = 1'b1;
    #1;
    checks++; if ({osr_sel, deemp_enable, volume_q15} !== {4'd0, 1'b0, 16'h7FFF}) begin errors++; $display("FAIL rm_values: got %h/%b/%h exp 0/0/7fff", osr_sel, deemp_enable, volume_q15); end
    checks++; if ({soft_mute, cfg_done, busy, flush_timeout} !== 4'b0000) begin errors++; $display("FAIL rm_flags: got %b exp 0000", {soft_mute, cfg_done, busy, flush_timeout}); end
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (cfg_done) seen_done = 1'b1;
    end
    checks++; if ({seen_done, cfg_ready} !== 2'b01) begin errors++; $display("FAIL rm_no_done: got %b exp 01", {seen_done, cfg_ready}); end
  endtask

  task automatic test_flush_wait;
    send_cfg(4'd6, 1'b1, 16'h5000);
    repeat (513) @(negedge clk);
    send_pulses(2);
`ifdef DSP_SEQ_FLUSH_TIMEOUT_EN
    repeat (4095) @(negedge clk);
    checks++; if ({flush_timeout, busy, soft_mute} !== 3'b011) begin errors++; $display("FAIL to_early: got %b exp 011", {flush_timeout, busy, soft_mute}); end
    @(negedge clk);
    checks++; if ({flush_timeout, busy, soft_mute} !== 3'b110) begin errors++; $display("FAIL to_fire: got %b exp 110", {flush_timeout, busy, soft_mute}); end
    repeat (512) @(negedge clk);
    checks++; if ({cfg_done, busy, flush_timeout} !== 3'b101) begin errors++; $display("FAIL to_done: got %b exp 101", {cfg_done, busy, flush_timeout}); end
`else
    repeat (5000) @(negedge clk);
    checks++; if ({busy, cfg_ready, soft_mute, flush_timeout} !== 4'b1010) begin errors++; $display("FAIL fw_stuck: got %b exp 1010", {busy, cfg_ready, soft_mute, flush_timeout}); end
    checks++; if (osr_sel !== 4'd6) begin errors++; $display("FAIL fw_osr: got %h exp 6", osr_sel); end
`endif
  endtask

  initial begin
    rst            = 1'b1;
    cfg_valid      = 1'b0;
    cfg_osr_sel    = 4'd0;
    cfg_deemp      = 1'b0;
    cfg_volume_q15 = 16'h0000;
    host_mute      = 1'b0;
    dsp_out_valid  = 1'b0;
    repeat (2) @(negedge clk);
    test_reset;
    test_slow_path;
    test_fast_path;
    test_busy_ignore;
    test_host_mute;
    test_reset_mid;
    test_flush_wait;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
